dp_controller: RTL and testbench
================================

Name: dp_controller

Overview:
- Sequencing controller that drives the control inputs of the 4-register/tmp/ALU datapath block.
- Accepts one 8-bit instruction per start pulse and emits a multi-cycle sequence of datapath controls: register write select/enable, tmp load, mux selects and ALU op.
- Signals done when the sequence completes.
- Sits between the instruction source (testbench or a future sequencer) and the datapath.

Parameters:
- None. Widths are fixed by the datapath interface.

Ports:
clk      input   1  rising-edge clock
reset_n  input   1  asynchronous, active-low reset
start    input   1  request to execute instr; sampled only in IDLE
instr    input   8  [7:5] opcode, [4] reserved (ignored), [3:2] Rd, [1:0] Rm
sr       output  3  datapath write-source select, one-hot: 001=in, 010=alu_out, 100=tmp
Rn       output  2  destination register index
w        output  1  register-file write enable
aluop    output  2  00=xor, 01=and, 10=shl, 11=pass B
lt       output  1  tmp load enable
tsel     output  3  tmp source, one-hot: 001=alu_out, 010=R0, 100=Bin
bsel     output  3  B-operand select, one-hot: 001=R1, 010=R2, 100=R3; 000 gives B=0
busy     output  1  high whenever state != IDLE
done     output  1  one-cycle pulse at end of every accepted instruction
err      output  1  illegal opcode flag

Behaviour:
- Reset: asynchronous on reset_n low; takes effect immediately, even mid-instruction.
  - State=IDLE, instruction register IR=0, err=0.
  - All control outputs, busy and done are 0 while in reset.
  - No write (w=1) may be issued in the cycle reset deasserts.
- States: IDLE, TMP, WB, DONE.
- Start acceptance: in IDLE with start=1 at a rising edge, instr is captured into IR and err is cleared.
  - start outside IDLE is ignored; no queueing.
  - instr is don't-care after capture.
- Next state from IDLE on start, by opcode:
  - 000 LOAD: WB
  - 001 MOV, 010 XOR, 011 AND, 100 SHL: TMP
  - 101/110/111 illegal: DONE, with err set to 1
- Sequencing: TMP→WB, WB→DONE, DONE→IDLE, unconditionally.
- Control outputs are Moore decodes of state and IR. Any output not listed for a state is 0. In IDLE and DONE all controls are 0.
- bsel mapping for Rm: 01→001, 10→010, 11→100, 00→000.
- TMP state:
  - MOV, Rm=00: lt=1, tsel=010.
  - MOV, Rm≠00: lt=1, tsel=100, bsel=onehot(Rm).
  - XOR/AND/SHL: lt=1, tsel=010 (tmp<=R0).
- WB state, all with Rn=IR[3:2], w=1:
  - LOAD: sr=001.
  - MOV: sr=100.
  - XOR: sr=010, aluop=00, bsel=onehot(Rm).
  - AND: as XOR with aluop=01.
  - SHL: sr=010, aluop=10; bsel=000.
- Rm=00 on XOR/AND is legal and yields B=0, so Rd<=R0^0 or R0&0.
- Latency from the accepting edge:
  - LOAD: 2 cycles to done (WB, DONE).
  - MOV/XOR/AND/SHL: 3 cycles (TMP, WB, DONE).
  - Illegal: 1 cycle (DONE).
- done=1 exactly during DONE. busy=1 in TMP, WB and DONE.
- err stays 1 from the illegal-opcode DONE cycle until the next accepted start. Legal instructions leave err=0.
- Invariants, checked by assertion:
  - w=1 occurs only in WB, exactly once per legal instruction.
  - lt and w are never both 1.
  - sr, tsel and bsel are each one-hot or zero.

Test Plan:
- Reset mid-WB of XOR, reset_n low for 1 cycle → w, lt, busy and done drop immediately; state IDLE; no further w until a new start.
- LOAD: instr=0x04, start 1 cycle with datapath in=0x5A → next cycle sr=001, Rn=01, w=1; following cycle done=1; R1=0x5A; busy=0 after.
- XOR: R0=0x0F, R1=0x3C, instr=0x49 → TMP (lt=1, tsel=010), then WB (sr=010, aluop=00, bsel=001, Rn=10, w=1), then done; R2=0x33.
- SHL and MOV: R0=0x81, instr=0x8C (SHL R3) → R3=0x02. Then instr=0x26 (MOV R1←R2) → TMP with tsel=100, bsel=010; R1=R2.
- Illegal: instr=0xE0 → done and err=1 on the cycle after accept; w and lt never asserted. The next legal start clears err.
- Start held high across a full MOV → exactly one instruction per IDLE visit; start during busy ignored; back-to-back instructions accepted on each IDLE cycle.

Source files
------------

// File: rtl/dp_controller.sv
// Instruction sequencer for the 4-register/tmp/ALU datapath: accepts one opcode per
// start pulse in IDLE and steps TMP/WB/DONE, decoding datapath controls from state and IR.
module dp_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] instr,
   output logic [2:0] sr,
   output logic [1:0] Rn,
   output logic       w,
   output logic [1:0] aluop,
   output logic       lt,
   output logic [2:0] tsel,
   output logic [2:0] bsel,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_TMP  = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_MOV  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_SHL  = 3'd4;

   logic [1:0] state_reg;
   logic [7:0] ir_reg;
   logic       err_reg;

   logic [2:0] opcode;
   logic [1:0] rd;
   logic [1:0] rm;
   logic [2:0] bsel_rm;
   logic [2:0] new_op;
   logic       unused_reserved;

   assign opcode          = ir_reg[7:5];
   assign rd              = ir_reg[3:2];
   assign rm              = ir_reg[1:0];
   assign new_op          = instr[7:5];
   assign unused_reserved = ir_reg[4];

   always_comb begin
      bsel_rm = 3'b000;
      case (rm)
         2'b01:   bsel_rm = 3'b001;
         2'b10:   bsel_rm = 3'b010;
         2'b11:   bsel_rm = 3'b100;
         default: bsel_rm = 3'b000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
         ir_reg    <= 8'h00;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  ir_reg <= instr;
                  // Illegal opcodes skip straight to DONE so the source still sees a done pulse.
                  if (new_op == OP_LOAD) begin
                     state_reg <= S_WB;
                     err_reg   <= 1'b0;
                  end else if (new_op <= OP_SHL) begin
                     state_reg <= S_TMP;
                     err_reg   <= 1'b0;
                  end else begin
                     state_reg <= S_DONE;
                     err_reg   <= 1'b1;
                  end
               end
            end
            S_TMP:   state_reg <= S_WB;
            S_WB:    state_reg <= S_DONE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      sr    = 3'b000;
      Rn    = 2'b00;
      w     = 1'b0;
      aluop = 2'b00;
      lt    = 1'b0;
      tsel  = 3'b000;
      bsel  = 3'b000;
      case (state_reg)
         S_TMP: begin
            case (opcode)
               OP_MOV: begin
                  lt = 1'b1;
                  if (rm == 2'b00) begin
                     tsel = 3'b010;
                  end else begin
                     tsel = 3'b100;
                     bsel = bsel_rm;
                  end
               end
               OP_XOR, OP_AND, OP_SHL: begin
                  lt   = 1'b1;
                  tsel = 3'b010;
               end
               default: ;
            endcase
         end
         S_WB: begin
            case (opcode)
               OP_LOAD: begin
                  Rn = rd;
                  w  = 1'b1;
                  sr = 3'b001;
               end
               OP_MOV: begin
                  Rn = rd;
                  w  = 1'b1;
                  sr = 3'b100;
               end
               OP_XOR, OP_AND: begin
                  Rn    = rd;
                  w     = 1'b1;
                  sr    = 3'b010;
                  aluop = (opcode == OP_AND) ? 2'b01 : 2'b00;
                  bsel  = bsel_rm;
               end
               OP_SHL: begin
                  Rn    = rd;
                  w     = 1'b1;
                  sr    = 3'b010;
                  aluop = 2'b10;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign busy = (state_reg != S_IDLE);
   assign done = (state_reg == S_DONE);
   assign err  = err_reg;

`ifndef SYNTHESIS
   a_w_only_in_wb:  assert property (@(posedge clk) disable iff (!reset_n) w |-> (state_reg == S_WB));
   a_lt_w_excl:     assert property (@(posedge clk) disable iff (!reset_n) !(lt && w));
   a_sr_onehot0:    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(sr));
   a_tsel_onehot0:  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(tsel));
   a_bsel_onehot0:  assert property (@(posedge clk) disable iff (!reset_n) $onehot0(bsel));
`endif

endmodule

// File: tb/tb_dp_controller.sv
// Directed bench for dp_controller: table of instructions with per-cycle expected controls,
// plus hand-written sequences for async reset mid-instruction and start held high.
module tb_dp_controller;

   typedef struct packed {
      logic [2:0] sr;
      logic [1:0] rn;
      logic       w;
      logic [1:0] aluop;
      logic       lt;
      logic [2:0] tsel;
      logic [2:0] bsel;
      logic       busy;
      logic       done;
      logic       err;
   } ctl_t;

   typedef struct packed {
      logic [7:0]      instr;
      logic [1:0]      n;
      ctl_t [2:0]      e;
   } vec_t;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] instr;
   logic [2:0] sr;
   logic [1:0] Rn;
   logic       w;
   logic [1:0] aluop;
   logic       lt;
   logic [2:0] tsel;
   logic [2:0] bsel;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;

   dp_controller dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .instr   (instr),
      .sr      (sr),
      .Rn      (Rn),
      .w       (w),
      .aluop   (aluop),
      .lt      (lt),
      .tsel    (tsel),
      .bsel    (bsel),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_t c(input logic [2:0] sr_e, input logic [1:0] rn_e, input logic w_e,
                              input logic [1:0] aluop_e, input logic lt_e, input logic [2:0] tsel_e,
                              input logic [2:0] bsel_e, input logic busy_e, input logic done_e,
                              input logic err_e);
      ctl_t r;
      r.sr = sr_e; r.rn = rn_e; r.w = w_e; r.aluop = aluop_e; r.lt = lt_e;
      r.tsel = tsel_e; r.bsel = bsel_e; r.busy = busy_e; r.done = done_e; r.err = err_e;
      return r;
   endfunction

   function automatic ctl_t actual();
      return c(sr, Rn, w, aluop, lt, tsel, bsel, busy, done, err);
   endfunction

   task automatic chk(input string name, input ctl_t exp);
      ctl_t act;
      act = actual();
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got sr=%b Rn=%0d w=%b aluop=%b lt=%b tsel=%b bsel=%b busy=%b done=%b err=%b ; want sr=%b Rn=%0d w=%b aluop=%b lt=%b tsel=%b bsel=%b busy=%b done=%b err=%b",
                  name, act.sr, act.rn, act.w, act.aluop, act.lt, act.tsel, act.bsel, act.busy, act.done, act.err,
                  exp.sr, exp.rn, exp.w, exp.aluop, exp.lt, exp.tsel, exp.bsel, exp.busy, exp.done, exp.err);
      end else begin
         $display("ok   %s", name);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end else begin
         $display("ok   %s", name);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end else begin
         $display("ok   %s", name);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkv(input logic [7:0] i, input logic [1:0] n,
                                input ctl_t e0, input ctl_t e1, input ctl_t e2);
      vec_t v;
      v.instr = i; v.n = n; v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
      return v;
   endfunction

   localparam int NV = 11;
   vec_t vecs [NV];
   ctl_t zero_c;
   ctl_t idle_e;
   int   n_done;
   int   n_w;

   initial begin
      zero_c = c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

      // LOAD R1
      vecs[0]  = mkv(8'h04, 2'd2,
                     c(3'b001, 2'd1, 1'b1, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0), zero_c);
      // XOR R2 <- R0 ^ R1
      vecs[1]  = mkv(8'h49, 2'd3,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b010, 2'd2, 1'b1, 2'b00, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
      // SHL R3
      vecs[2]  = mkv(8'h8C, 2'd3,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b010, 2'd3, 1'b1, 2'b10, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
      // MOV R1 <- R2
      vecs[3]  = mkv(8'h26, 2'd3,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b1, 3'b100, 3'b010, 1'b1, 1'b0, 1'b0),
                     c(3'b100, 2'd1, 1'b1, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
      // MOV R2 <- R0 (Rm=00 goes through tsel=R0)
      vecs[4]  = mkv(8'h28, 2'd3,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b100, 2'd2, 1'b1, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
      // AND R2 <- R0 & R3, reserved bit set
      vecs[5]  = mkv(8'h7B, 2'd3,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b010, 2'd2, 1'b1, 2'b01, 1'b0, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
      // XOR R1 <- R0 ^ 0
      vecs[6]  = mkv(8'h44, 2'd3,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b010, 2'd1, 1'b1, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
      // illegal 111
      vecs[7]  = mkv(8'hE0, 2'd1,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1), zero_c, zero_c);
      // LOAD R3 clears err
      vecs[8]  = mkv(8'h0C, 2'd2,
                     c(3'b001, 2'd3, 1'b1, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0),
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0), zero_c);
      // illegal 101, then illegal 110 keeps err high
      vecs[9]  = mkv(8'hA5, 2'd1,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1), zero_c, zero_c);
      vecs[10] = mkv(8'hDF, 2'd1,
                     c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1), zero_c, zero_c);

      reset_n = 1'b0;
      start   = 1'b0;
      instr   = 8'h00;
      #3;
      chk("reset_state", zero_c);
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("idle_after_reset", zero_c);

      for (int i = 0; i < NV; i++) begin
         start = 1'b1;
         instr = vecs[i].instr;
         step();
         start = 1'b0;
         instr = 8'hFF;
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            chk($sformatf("vec%0d_instr%02h_cyc%0d", i, vecs[i].instr, k), vecs[i].e[k]);
            if (k < int'(vecs[i].n) - 1) step();
         end
         step();
         idle_e     = zero_c;
         idle_e.err = vecs[i].e[vecs[i].n - 1].err;
         chk($sformatf("vec%0d_back_to_idle", i), idle_e);
      end

      // err is high here; reset in IDLE must clear it immediately
      #2 reset_n = 1'b0;
      #1 chk("reset_clears_err", zero_c);
      step();
      reset_n = 1'b1;
      step();

      // Async reset in the middle of an XOR writeback
      start = 1'b1;
      instr = 8'h49;
      step();
      start = 1'b0;
      step();
      chk("xor_wb_before_reset",
          c(3'b010, 2'd2, 1'b1, 2'b00, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0));
      #2 reset_n = 1'b0;
      #1 chk("reset_mid_wb_immediate", zero_c);
      step();
      chk("reset_mid_wb_held", zero_c);
      reset_n = 1'b1;
      n_w = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (w || busy) n_w++;
      end
      chk_int("no_activity_after_reset", n_w, 0);

      // Start held high: MOV accepted, instr changed mid-flight, then next IDLE accepts illegal
      start = 1'b1;
      instr = 8'h26;
      step();
      instr = 8'hE0;
      chk("held_mov_tmp",
          c(3'b000, 2'd0, 1'b0, 2'b00, 1'b1, 3'b100, 3'b010, 1'b1, 1'b0, 1'b0));
      step();
      chk("held_mov_wb",
          c(3'b100, 2'd1, 1'b1, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0));
      step();
      chk("held_mov_done",
          c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0));
      step();
      chk("held_idle_visit", zero_c);
      step();
      chk("held_next_accept_illegal",
          c(3'b000, 2'd0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1));

      // Back-to-back LOADs with start held: one instruction per IDLE visit
      instr  = 8'h04;
      n_done = 0;
      n_w    = 0;
      for (int k = 0; k < 9; k++) begin
         step();
         if (done) n_done++;
         if (w) n_w++;
      end
      start = 1'b0;
      chk_int("held_load_done_count", n_done, 3);
      chk_int("held_load_w_count", n_w, 3);
      chk_bit("held_load_err_cleared", err, 1'b0);
      step();
      step();
      chk_bit("idle_after_held", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
